// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - state encodings and sizing helper for seq_nbit_adder
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width; never below one bit so a single-digit adder still has a counter.
  function automatic int clog2_min1(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit adder slice with carry in/out
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/seq_nbit_adder.sv
// rtl/seq_nbit_adder.sv - multi-cycle WIDTH-bit adder, DIGIT bits per clock; optional ADDER_OVERFLOW_EN
module seq_nbit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             carry
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = clog2_min1(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("seq_nbit_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       a_sr;
  logic [WIDTH-1:0]       b_sr;
  logic [WIDTH-1:0]       res_sr;
  logic                   c_r;
  logic [DIGIT-1:0]       dsum;
  logic                   dco;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a  (a_sr[DIGIT-1:0]),
    .b  (b_sr[DIGIT-1:0]),
    .ci (c_r),
    .s  (dsum),
    .co (dco)
  );

  // New digit enters at the top; after NDIG shifts the low digit sits at bit 0.
  assign res_cat  = {dsum, res_sr};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

`ifdef ADDER_OVERFLOW_EN
  logic x_msb;
  logic y_msb;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      c_r    <= 1'b0;
      z      <= '0;
      carry  <= 1'b0;
`ifdef ADDER_OVERFLOW_EN
      x_msb    <= 1'b0;
      y_msb    <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          c_r    <= dco;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            z     <= res_next;
            carry <= dco;
`ifdef ADDER_OVERFLOW_EN
            overflow <= (x_msb == y_msb) && (dsum[DIGIT-1] != x_msb);
`endif
            state <= ST_DONE;
          end
        end
        // IDLE, DONE and the unused encoding all accept a new operation.
        default: begin
          if (start) begin
            a_sr  <= x;
            b_sr  <= y;
            c_r   <= cin;
            cnt   <= '0;
`ifdef ADDER_OVERFLOW_EN
            x_msb <= x[WIDTH-1];
            y_msb <= y[WIDTH-1];
`endif
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_nbit_adder.sv
// tb/tb_seq_nbit_adder.sv - scoreboard bench for seq_nbit_adder (8/2 and 2/1 instances)
module tb_seq_nbit_adder;

  typedef struct packed {
    logic [7:0] z;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       cin = 1'b0;
  logic       busy, done, carry;
  logic [7:0] z;

  logic       start2 = 1'b0;
  logic [1:0] x2 = '0;
  logic [1:0] y2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, carry2;
  logic [1:0] z2;

`ifdef ADDER_OVERFLOW_EN
  logic overflow, overflow2;
`endif

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  logic [3:0] q2[$];
  logic [7:0] prev_z = '0;
  logic       prev_c = 1'b0;

  always #5 clk = ~clk;

  seq_nbit_adder #(.WIDTH(8), .DIGIT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .cin(cin),
    .busy(busy), .done(done), .z(z), .carry(carry)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  seq_nbit_adder #(.WIDTH(2), .DIGIT(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .x(x2), .y(y2), .cin(cin2),
    .busy(busy2), .done(done2), .z(z2), .carry(carry2)
`ifdef ADDER_OVERFLOW_EN
    , .overflow(overflow2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op8(input logic [7:0] xv, input logic [7:0] yv, input logic ci);
    logic [8:0] s;
    exp_t e;
    x = xv; y = yv; cin = ci; start = 1'b1;
    s = {1'b0, xv} + {1'b0, yv} + {8'd0, ci};
    e.z = s[7:0];
    e.c = s[8];
    e.v = (xv[7] == yv[7]) && (s[7] != xv[7]);
    q.push_back(e);
  endtask

  task automatic wait_op8(input bit poke, input bit chain,
                          input logic [7:0] nx, input logic [7:0] ny, input logic nci);
    int cyc;
    exp_t e;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc <= 40) begin
      check("busy_run", busy, 1);
      check("z_hold", {carry, z}, {prev_c, prev_z});
      if (poke && cyc == 2) begin
        x = 8'hAA; y = 8'hAA; cin = 1'b1; start = 1'b1;
      end
      if (poke && cyc == 3) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check("done_seen", done, 1);
    check("latency", cyc, 5);
    check("busy_in_done", busy, 0);
    check("sb_depth", q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("z", z, e.z);
      check("carry", carry, e.c);
`ifdef ADDER_OVERFLOW_EN
      check("overflow", overflow, e.v);
`endif
      prev_z = e.z;
      prev_c = e.c;
    end
    if (chain) begin
      start_op8(nx, ny, nci);
    end else begin
      @(negedge clk);
      check("done_pulse", done, 0);
    end
  endtask

  task automatic op2(input logic [1:0] xv, input logic [1:0] yv);
    int cyc;
    logic [3:0] e;
    logic [2:0] s;
    @(negedge clk);
    x2 = xv; y2 = yv; cin2 = 1'b0; start2 = 1'b1;
    s = {1'b0, xv} + {1'b0, yv};
    q2.push_back({(xv[1] == yv[1]) && (s[1] != xv[1]), s});
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc <= 20) begin
      check("busy2_run", busy2, 1);
      @(negedge clk);
      cyc++;
    end
    check("done2_seen", done2, 1);
    check("latency2", cyc, 3);
    check("sb2_depth", q2.size(), 1);
    if (q2.size() > 0) begin
      e = q2.pop_front();
      check("z2", z2, e[1:0]);
      check("carry2", carry2, e[2]);
`ifdef ADDER_OVERFLOW_EN
      check("overflow2", overflow2, e[3]);
`endif
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_z", z, 0);
    check("rst_carry", carry, 0);
`ifdef ADDER_OVERFLOW_EN
    check("rst_overflow", overflow, 0);
`endif
    reset = 1'b0;

    @(negedge clk); start_op8(8'h05, 8'h03, 1'b0); wait_op8(0, 0, '0, '0, 1'b0);
    @(negedge clk); start_op8(8'hFF, 8'h01, 1'b0); wait_op8(0, 0, '0, '0, 1'b0);
    @(negedge clk); start_op8(8'hFF, 8'hFF, 1'b1); wait_op8(0, 0, '0, '0, 1'b0);
    @(negedge clk); start_op8(8'h7F, 8'h01, 1'b0); wait_op8(0, 0, '0, '0, 1'b0);
    @(negedge clk); start_op8(8'h80, 8'h80, 1'b0); wait_op8(0, 0, '0, '0, 1'b0);
    @(negedge clk); start_op8(8'h10, 8'h20, 1'b0); wait_op8(0, 0, '0, '0, 1'b0);

    // start pulsed mid-run with new operands must be ignored
    @(negedge clk); start_op8(8'h12, 8'h34, 1'b0); wait_op8(1, 0, '0, '0, 1'b0);

    // start held in DONE launches the next op back to back
    @(negedge clk); start_op8(8'h3C, 8'h0F, 1'b1); wait_op8(0, 1, 8'hC8, 8'h40, 1'b0);
    wait_op8(0, 0, '0, '0, 1'b0);

    // reset in the second RUN cycle aborts without a done pulse
    @(negedge clk); start_op8(8'h55, 8'h22, 1'b0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_z", z, 0);
    check("abort_carry", carry, 0);
`ifdef ADDER_OVERFLOW_EN
    check("abort_overflow", overflow, 0);
`endif
    reset = 1'b0;
    void'(q.pop_back());
    prev_z = '0;
    prev_c = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end

    op2(2'b01, 2'b01);
    op2(2'b11, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
